// File: rtl/lm80c_uart_pkg.sv
// rtl/lm80c_uart_pkg.sv - shared types and constants for the LM80C SIO UART
package lm80c_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_t;

  localparam int DATA_BITS    = 8;
  localparam int SYS_CLOCK_HZ = 29_491_200;

endpackage

// File: rtl/lm80c_sync_fifo.sv
// rtl/lm80c_sync_fifo.sv - single-clock show-ahead FIFO with occupancy counter
module lm80c_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  // Full/empty come from registered state, so a write while full is dropped
  // even when a pop happens on the same edge.
  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lm80c_uart_tx.sv
// rtl/lm80c_uart_tx.sv - SIO channel A transmitter: TX FIFO plus async frame serialiser
module lm80c_uart_tx
  import lm80c_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       two_stop,
  input  logic       cts_n,
  input  logic       clr_ovf,
  output logic       txd,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic [6:0] level,
  output logic       overflow
);

  localparam int                CNT_W   = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BAUD_DIV - 1);
  localparam int                LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [2:0]        LAST_IDX = 3'(DATA_BITS - 1);

  tx_state_t              state, state_d;
  logic [CNT_W-1:0]       baud_cnt, cnt_d;
  logic [DATA_BITS-1:0]   shift, shift_d;
  logic [2:0]             bit_idx, idx_d;
  logic                   par_acc, par_d;
  logic                   cfg_par_en, pen_d;
  logic                   cfg_two_stop, two_d;
  logic                   txd_q, txd_d;
  logic                   overflow_q;
  logic                   pop;
  logic                   start_frame;
  logic                   can_start;
  logic                   bit_end;
  logic [DATA_BITS-1:0]   fifo_dout;
  logic [LVL_W-1:0]       fifo_level;

  lm80c_sync_fifo #(
    .DATA_W (DATA_BITS),
    .DEPTH  (FIFO_DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr),
    .pop   (pop),
    .din   (din),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign can_start = !empty && !cts_n;
  assign bit_end   = (baud_cnt == '0);
  assign txd       = txd_q;
  assign busy      = (state != IDLE);
  assign level     = 7'(fifo_level);
  assign overflow  = overflow_q;

  always_comb begin
    state_d     = state;
    cnt_d       = baud_cnt;
    shift_d     = shift;
    idx_d       = bit_idx;
    par_d       = par_acc;
    pen_d       = cfg_par_en;
    two_d       = cfg_two_stop;
    txd_d       = txd_q;
    pop         = 1'b0;
    start_frame = 1'b0;

    if (state != IDLE && !bit_end) begin
      cnt_d = baud_cnt - 1'b1;
    end

    case (state)
      IDLE: begin
        start_frame = can_start;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = CNT_MAX;
          idx_d   = '0;
          txd_d   = shift[0];
          par_d   = par_acc ^ shift[0];
          shift_d = shift >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = CNT_MAX;
          if (bit_idx == LAST_IDX) begin
            state_d = cfg_par_en ? PARITY : STOP1;
            txd_d   = cfg_par_en ? par_acc : 1'b1;
          end else begin
            idx_d   = bit_idx + 1'b1;
            txd_d   = shift[0];
            par_d   = par_acc ^ shift[0];
            shift_d = shift >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP1;
          cnt_d   = CNT_MAX;
          txd_d   = 1'b1;
        end
      end
      STOP1, STOP2: begin
        if (bit_end) begin
          if (state == STOP1 && cfg_two_stop) begin
            state_d = STOP2;
            cnt_d   = CNT_MAX;
            txd_d   = 1'b1;
          end else begin
            // Chain straight into the next START so queued bytes leave with no idle gap.
            start_frame = can_start;
            state_d     = IDLE;
            txd_d       = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
      end
    endcase

    // Frame config is captured here only; mid-frame changes wait for the next frame.
    if (start_frame) begin
      pop     = 1'b1;
      state_d = START;
      cnt_d   = CNT_MAX;
      shift_d = fifo_dout;
      pen_d   = parity_en;
      two_d   = two_stop;
      par_d   = parity_odd;
      txd_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      shift        <= '0;
      bit_idx      <= '0;
      par_acc      <= 1'b0;
      cfg_par_en   <= 1'b0;
      cfg_two_stop <= 1'b0;
      txd_q        <= 1'b1;
    end else begin
      state        <= state_d;
      baud_cnt     <= cnt_d;
      shift        <= shift_d;
      bit_idx      <= idx_d;
      par_acc      <= par_d;
      cfg_par_en   <= pen_d;
      cfg_two_stop <= two_d;
      txd_q        <= txd_d;
    end
  end

  // A new overflow wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (wr && full) begin
      overflow_q <= 1'b1;
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lm80c_uart_tx.sv
// tb/tb_lm80c_uart_tx.sv - directed self-checking bench for lm80c_uart_tx
module tb_lm80c_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       two_stop = 1'b0;
  logic       cts_n = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       txd;
  logic       full;
  logic       empty;
  logic       busy;
  logic [6:0] level;
  logic       overflow;

  int total = 0;
  int bad = 0;

  lm80c_uart_tx #(
    .BAUD_DIV   (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .din        (din),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .cts_n      (cts_n),
    .clr_ovf    (clr_ovf),
    .txd        (txd),
    .full       (full),
    .empty      (empty),
    .busy       (busy),
    .level      (level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr  = 1'b1;
    din = b;
    tick();
    wr  = 1'b0;
  endtask

  // Starts at the first sample of START; ends one sample past the last stop clock.
  task automatic expect_frame(input logic [7:0] b, input logic pen, input logic pbit,
                              input logic two, input string name);
    logic [11:0] bits;
    int nb;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
    nb = 10;
    if (pen) begin
      bits[9] = pbit;
      nb = 11;
    end
    if (two) nb++;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < 4; c++) begin
        total++;
        if (txd !== bits[i] || busy !== 1'b1) begin
          bad++;
          $display("FAIL %s bit%0d clk%0d txd=%b busy=%b want txd=%b busy=1", name, i, c, txd, busy, bits[i]);
        end
        tick();
      end
    end
  endtask

  task automatic check_idle(input string name, input logic [6:0] want_level);
    total++;
    if (txd !== 1'b1 || busy !== 1'b0 || level !== want_level) begin
      bad++;
      $display("FAIL %s txd=%b busy=%b level=%0d want txd=1 busy=0 level=%0d", name, txd, busy, level, want_level);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if ({txd, busy, empty, full, level, overflow} !== {1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state txd=%b busy=%b empty=%b full=%b level=%0d ovf=%b want 1 0 1 0 0 0",
               txd, busy, empty, full, level, overflow);
    end
  endtask

  task automatic test_8n1();
    cts_n = 1'b0;
    write_byte(8'h55);
    total++;
    if (txd !== 1'b1 || level !== 7'd1) begin
      bad++;
      $display("FAIL 8n1_after_wr txd=%b level=%0d want txd=1 level=1", txd, level);
    end
    tick();
    total++;
    if (txd !== 1'b0 || level !== 7'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL 8n1_latency txd=%b level=%0d busy=%b want 0 0 1", txd, level, busy);
    end
    expect_frame(8'h55, 1'b0, 1'b0, 1'b0, "8n1_55");
    check_idle("8n1_end", 7'd0);
  endtask

  task automatic test_parity();
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    two_stop   = 1'b1;
    write_byte(8'h07);
    tick();
    // Mid-frame config change must not affect this frame.
    parity_odd = 1'b1;
    two_stop   = 1'b0;
    expect_frame(8'h07, 1'b1, 1'b1, 1'b1, "even_07");
    check_idle("even_end", 7'd0);
    two_stop = 1'b1;
    write_byte(8'h07);
    tick();
    expect_frame(8'h07, 1'b1, 1'b0, 1'b1, "odd_07");
    check_idle("odd_end", 7'd0);
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
  endtask

  task automatic test_back_to_back();
    cts_n = 1'b1;
    write_byte(8'hA1);
    write_byte(8'h3C);
    write_byte(8'hF0);
    write_byte(8'h0F);
    write_byte(8'hEE);
    total++;
    if (level !== 7'd4 || full !== 1'b1 || overflow !== 1'b1 || busy !== 1'b0 || txd !== 1'b1) begin
      bad++;
      $display("FAIL burst_fill level=%0d full=%b ovf=%b busy=%b txd=%b want 4 1 1 0 1",
               level, full, overflow, busy, txd);
    end
    cts_n = 1'b0;
    tick();
    expect_frame(8'hA1, 1'b0, 1'b0, 1'b0, "b2b_A1");
    expect_frame(8'h3C, 1'b0, 1'b0, 1'b0, "b2b_3C");
    expect_frame(8'hF0, 1'b0, 1'b0, 1'b0, "b2b_F0");
    expect_frame(8'h0F, 1'b0, 1'b0, 1'b0, "b2b_0F");
    check_idle("b2b_end", 7'd0);
    tick();
    tick();
    check_idle("b2b_dropped", 7'd0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL clr_ovf ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_cts_mid();
    cts_n = 1'b0;
    write_byte(8'h11);
    write_byte(8'h22);
    cts_n = 1'b1;
    expect_frame(8'h11, 1'b0, 1'b0, 1'b0, "cts_11");
    for (int i = 0; i < 8; i++) begin
      check_idle("cts_hold", 7'd1);
      tick();
    end
    cts_n = 1'b0;
    tick();
    total++;
    if (txd !== 1'b0 || level !== 7'd0) begin
      bad++;
      $display("FAIL cts_release txd=%b level=%0d want 0 0", txd, level);
    end
    expect_frame(8'h22, 1'b0, 1'b0, 1'b0, "cts_22");
    check_idle("cts_end", 7'd0);
  endtask

  task automatic test_reset_mid();
    cts_n = 1'b0;
    write_byte(8'hFF);
    write_byte(8'h00);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    total++;
    if (txd !== 1'b1 || busy !== 1'b0 || empty !== 1'b1 || level !== 7'd0) begin
      bad++;
      $display("FAIL reset_mid txd=%b busy=%b empty=%b level=%0d want 1 0 1 0", txd, busy, empty, level);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_idle("reset_mid_after", 7'd0);
    end
  endtask

  task automatic test_same_cycle();
    cts_n = 1'b1;
    write_byte(8'hAA);
    cts_n = 1'b0;
    write_byte(8'hBB);
    total++;
    if (level !== 7'd1 || txd !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL push_pop level=%0d txd=%b busy=%b want 1 0 1", level, txd, busy);
    end
    expect_frame(8'hAA, 1'b0, 1'b0, 1'b0, "pp_AA");
    expect_frame(8'hBB, 1'b0, 1'b0, 1'b0, "pp_BB");
    check_idle("pp_end", 7'd0);

    cts_n = 1'b1;
    write_byte(8'hC1);
    write_byte(8'hC2);
    write_byte(8'hC3);
    write_byte(8'hC4);
    cts_n = 1'b0;
    write_byte(8'hC5);
    total++;
    if (overflow !== 1'b1 || level !== 7'd3 || full !== 1'b0) begin
      bad++;
      $display("FAIL full_pop ovf=%b level=%0d full=%b want 1 3 0", overflow, level, full);
    end
    expect_frame(8'hC1, 1'b0, 1'b0, 1'b0, "fp_C1");
    expect_frame(8'hC2, 1'b0, 1'b0, 1'b0, "fp_C2");
    expect_frame(8'hC3, 1'b0, 1'b0, 1'b0, "fp_C3");
    expect_frame(8'hC4, 1'b0, 1'b0, 1'b0, "fp_C4");
    check_idle("fp_end", 7'd0);
    clr_ovf = 1'b1;
    wr      = 1'b1;
    din     = 8'h5A;
    cts_n   = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    wr = 1'b0;
    total++;
    if (overflow !== 1'b1 || level !== 7'd4) begin
      bad++;
      $display("FAIL clr_vs_ovf ovf=%b level=%0d want 1 4", overflow, level);
    end
    clr_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_cts_mid();
    test_reset_mid();
    test_same_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
